// File: rtl/instruction_fetch_unit_pkg.sv
// Shared MIPS pipeline definitions: text segment base, bubble encoding and
// the fetch FSM state type.
package mips_defs;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_next_pc.sv
// Combinational next-PC select (branch > jump > sequential) and the
// text-segment range/alignment check on the current PC.
module fetch_next_pc #(
  parameter logic [31:0] TEXT_BASE  = mips_defs::TEXT_BASE,
  parameter int unsigned TEXT_WORDS = 18
) (
  input  logic [31:0] pc_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic [3:0]  pc_plus4_hi_i,
  output logic [31:0] next_pc_o,
  output logic        pc_ok_o
);

  localparam logic [31:0] TEXT_LAST = TEXT_BASE + 32'(4 * (TEXT_WORDS - 1));

  always_comb begin
    next_pc_o = pc_i + 32'd4;
    if (branch_taken_i) begin
      next_pc_o = branch_target_i;
    end else if (jump_i) begin
      // J/JAL region comes from the PC+4 of the jump sitting in IF/ID
      next_pc_o = {pc_plus4_hi_i, jump_index_i, 2'b00};
    end
  end

  assign pc_ok_o = (pc_i >= TEXT_BASE) && (pc_i <= TEXT_LAST) && (pc_i[1:0] == 2'b00);

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC register, fetch FSM and the IF/ID pipeline register.
// Redirects beat flush and stall; out-of-segment PCs park the FSM in FAULT.
module instruction_fetch_unit
  import mips_defs::*;
#(
  parameter logic [31:0] TEXT_BASE  = mips_defs::TEXT_BASE,
  parameter int unsigned TEXT_WORDS = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] instruction,
  output logic [31:0] read_address,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_fault
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  ifid_instr_q;
  logic [31:0]  ifid_pc4_q;
  logic         ifid_valid_q;
  logic         fault_q;

  logic [31:0]  pc_d;
  logic         pc_ok;
  logic         redirect;

  assign redirect = branch_taken | jump;

  fetch_next_pc #(
    .TEXT_BASE (TEXT_BASE),
    .TEXT_WORDS(TEXT_WORDS)
  ) u_next_pc (
    .pc_i           (pc_q),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .jump_i         (jump),
    .jump_index_i   (jump_index),
    .pc_plus4_hi_i  (ifid_pc4_q[31:28]),
    .next_pc_o      (pc_d),
    .pc_ok_o        (pc_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= TEXT_BASE;
      ifid_instr_q <= NOP;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          ifid_instr_q <= NOP;
          ifid_pc4_q   <= '0;
          ifid_valid_q <= 1'b0;
          state_q      <= RUN;
        end
        RUN: begin
          if (!pc_ok) begin
            // The bad PC is frozen so software can see where fetch went wrong
            state_q      <= FAULT;
            fault_q      <= 1'b1;
            ifid_instr_q <= NOP;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
          end else if (redirect || flush) begin
            if (redirect) pc_q <= pc_d;
            ifid_instr_q <= NOP;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
          end else if (!stall) begin
            pc_q         <= pc_d;
            ifid_instr_q <= instruction;
            ifid_pc4_q   <= pc_d;
            ifid_valid_q <= 1'b1;
          end
        end
        FAULT: begin
          ifid_instr_q <= NOP;
          ifid_pc4_q   <= '0;
          ifid_valid_q <= 1'b0;
          if (redirect) begin
            pc_q    <= pc_d;
            state_q <= RUN;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign read_address      = pc_q;
  assign if_id_instruction = ifid_instr_q;
  assign if_id_pc_plus4    = ifid_pc4_q;
  assign if_id_valid       = ifid_valid_q;
  assign fetch_fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a behavioural model of the
// fetch rules pushes expected outputs; a monitor pops and compares each cycle.
module tb_instruction_fetch_unit;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int unsigned WORDS = 18;
  localparam logic [31:0] LAST  = BASE + 32'(4 * (WORDS - 1));

  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken, jump;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] instruction;
  logic [31:0] read_address, if_id_instruction, if_id_pc_plus4;
  logic        if_id_valid, fetch_fault;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .TEXT_BASE (BASE),
    .TEXT_WORDS(WORDS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_index       (jump_index),
    .instruction      (instruction),
    .read_address     (read_address),
    .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_valid      (if_id_valid),
    .fetch_fault      (fetch_fault)
  );

  // Instruction memory model; anything outside the segment reads as garbage
  logic [31:0] imem [WORDS];

  function automatic logic in_text(input logic [31:0] a);
    return (a >= BASE) && (a <= LAST) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (in_text(a)) return imem[off[31:2]];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb instruction = mem_read(read_address);

  typedef struct {
    logic [31:0] ra;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        val;
    logic        flt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model of the architectural fetch state
  logic [31:0] m_pc, m_ins, m_pc4;
  logic        m_val, m_fault, m_boot;

  task automatic bubble();
    m_ins = 32'h0; m_pc4 = 32'h0; m_val = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic st, input logic fl,
                            input logic br, input logic [31:0] bt,
                            input logic jp, input logic [25:0] ji);
    logic [31:0] tgt;
    tgt = br ? bt : {m_pc4[31:28], ji, 2'b00};
    if (r) begin
      m_pc = BASE; bubble(); m_fault = 1'b0; m_boot = 1'b1;
    end else if (m_boot) begin
      bubble(); m_boot = 1'b0;
    end else if (m_fault) begin
      bubble();
      if (br || jp) begin m_pc = tgt; m_fault = 1'b0; end
    end else if (!in_text(m_pc)) begin
      bubble(); m_fault = 1'b1;
    end else if (br || jp) begin
      bubble(); m_pc = tgt;
    end else if (fl) begin
      bubble();
    end else if (!st) begin
      m_ins = mem_read(m_pc); m_pc4 = m_pc + 32'd4; m_val = 1'b1; m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cycle(input logic r, input logic st, input logic fl,
                       input logic br, input logic [31:0] bt,
                       input logic jp, input logic [25:0] ji);
    exp_t e;
    @(negedge clk);
    #1;
    reset = r; stall = st; flush = fl;
    branch_taken = br; branch_target = bt; jump = jp; jump_index = ji;
    model_step(r, st, fl, br, bt, jp, ji);
    e.ra = m_pc; e.ins = m_ins; e.pc4 = m_pc4; e.val = m_val; e.flt = m_fault;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected snapshot per rising edge, checked at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("read_address", read_address, e.ra);
        cmp("if_id_instruction", if_id_instruction, e.ins);
        cmp("if_id_pc_plus4", if_id_pc_plus4, e.pc4);
        cmp("if_id_valid", 32'(if_id_valid), 32'(e.val));
        cmp("fetch_fault", 32'(fetch_fault), 32'(e.flt));
      end
    end
  end

  initial begin
    logic [31:0] bt;
    logic [25:0] ji;
    int unsigned sel;

    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_index = '0;
    m_pc = BASE; m_ins = 0; m_pc4 = 0; m_val = 0; m_fault = 0; m_boot = 1;
    for (int i = 0; i < int'(WORDS); i++) imem[i] = $urandom;
    imem[0] = 32'h012a4020;
    imem[1] = 32'h02328022;

    cycle(1'b1, 0, 0, 0, 0, 0, 0);
    cycle(1'b1, 0, 0, 0, 0, 0, 0);
    idle(2);                                             // boot bubble, word 0
    for (int i = 0; i < 3; i++) cycle(0, 1'b1, 0, 0, 0, 0, 0); // stall at 00400004
    idle(1);                                             // word 1
    cycle(0, 1'b1, 0, 1'b1, BASE, 0, 0);                 // branch beats stall
    idle(2);                                             // pc4 now 00400008
    cycle(0, 0, 0, 0, 0, 1'b1, 26'h0100001);             // jump -> 00400004
    idle(2);
    cycle(0, 0, 0, 1'b1, 32'h0040_0010, 1'b1, 26'h0100001); // branch wins
    cycle(0, 0, 1'b1, 0, 0, 0, 0);                       // flush
    cycle(0, 1'b1, 1'b1, 0, 0, 0, 0);                    // flush beats stall
    idle(20);                                            // run past word 17
    idle(3);                                             // fault holds
    cycle(0, 0, 0, 1'b1, BASE, 0, 0);                    // leave fault
    idle(3);
    cycle(0, 0, 0, 1'b1, BASE + 32'd6, 0, 0);            // misaligned redirect
    idle(3);
    cycle(1'b1, 0, 0, 0, 0, 0, 0);                       // reset inside FAULT
    idle(3);
    cycle(0, 1'b1, 0, 0, 0, 0, 0);
    cycle(1'b1, 1'b1, 0, 0, 0, 0, 0);                    // reset mid-stall
    idle(2);

    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 99);
      bt  = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
      if ($urandom_range(0, 7) == 0) bt = $urandom;
      ji  = 26'(32'h0010_0000 + $urandom_range(0, WORDS + 2));
      cycle(sel == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            sel >= 90, bt, sel >= 80 && sel < 95, ji);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d snapshots left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
